// File: rtl/rbz_reg_spi_ctrl_pkg.sv
// Shared definitions for the rbzero register SPI controller:
// register offsets (adr[3:2]), STATUS bit indices and FSM state encoding.
package rbz_reg_spi_ctrl_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_HOLD = 1;
  localparam int unsigned ST_OVF  = 2;
  localparam int unsigned ST_DONE = 3;

  localparam int unsigned LEN_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } spi_state_t;

endpackage

// File: rtl/rbz_spi_shifter.sv
// Shift register, bit counter and SCLK half-period divider for one SPI frame.
// Ports:
//   clk, reset    clock, async active-high reset
//   load          latch a new frame (data below the MSB, bit count, divider)
//   run           phase counter advances while the FSM is out of IDLE
//   step          one bit has been clocked out: shift and decrement count
//   data          frame payload without its MSB, MSB-aligned
//   nbits         frame length in bits (1..MAX_BITS)
//   div           half-period divider, H = div+1 cycles
//   phase_end_c   last cycle of the current H-cycle phase
//   next_bit      bit that follows the one currently on MOSI
//   bits_left     bits not yet clocked by a rising SCLK
module rbz_spi_shifter #(
  parameter int unsigned MAX_BITS = 32,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                run,
  input  logic                step,
  input  logic [MAX_BITS-2:0] data,
  input  logic [CNT_W-1:0]    nbits,
  input  logic [DIV_W-1:0]    div,
  output logic                phase_end_c,
  output logic                next_bit,
  output logic [CNT_W-1:0]    bits_left
);

  logic [MAX_BITS-2:0] sreg;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    phase;

  assign phase_end_c = (phase == div_q);
  assign next_bit    = sreg[MAX_BITS-2];

  // Frame state; the divider is latched at load so DIV writes only affect later frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      bits_left <= '0;
      div_q     <= '0;
      phase     <= '0;
    end else if (load) begin
      sreg      <= data;
      bits_left <= nbits;
      div_q     <= div;
      phase     <= '0;
    end else begin
      if (step) begin
        sreg      <= {sreg[MAX_BITS-3:0], 1'b0};
        bits_left <= bits_left - CNT_W'(1);
      end
      if (run) begin
        phase <= phase_end_c ? '0 : phase + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/rbz_reg_spi_ctrl.sv
// Wishbone-programmable SPI master driving the rbzero register port.
// One frame shifts while one more waits in the hold buffer.
// Ports:
//   clk, reset                 clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i       Wishbone control
//   wbs_sel_i                  byte lanes; sel==0 writes are acked and ignored
//   wbs_adr_i                  [3:2]: 0 TXDATA, 1 LEN, 2 DIV, 3 STATUS
//   wbs_dat_i / wbs_dat_o      write / registered read data
//   wbs_ack_o                  one-cycle registered ack
//   o_sclk, o_mosi, o_ss_n     SPI mode 0, MSB first
//   o_busy                     FSM active or hold buffer full
//   o_irq                      pulse as o_ss_n rises at end of frame
module rbz_reg_spi_ctrl
  import rbz_reg_spi_ctrl_pkg::*;
#(
  parameter int unsigned MAX_BITS = 32,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_RST  = 1,
  parameter int unsigned LEN_RST  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_ss_n,
  output logic        o_busy,
  output logic        o_irq
);

  localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);

  spi_state_t          state;
  logic [LEN_W-1:0]    len_q;
  logic [DIV_W-1:0]    div_reg;
  logic [MAX_BITS-1:0] hold_data;
  logic [CNT_W-1:0]    hold_len;
  logic                hold_full;
  logic                ovf;
  logic                done;

  logic                acc_c;
  logic                wr_c;
  logic                tx_wr_c;
  logic                st_wr_c;
  logic                load_c;
  logic                done_set_c;
  logic                ovf_set_c;
  logic                busy_c;
  logic [CNT_W-1:0]    len_eff_c;
  logic [MAX_BITS-1:0] aligned_c;
  logic [31:0]         rd_data_c;
  logic                phase_end_c;
  logic                next_bit;
  logic [CNT_W-1:0]    bits_left;
  logic                unused_ok;

  assign unused_ok  = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  assign acc_c      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_c       = acc_c & wbs_we_i & (|wbs_sel_i);
  assign tx_wr_c    = wr_c & (wbs_adr_i[3:2] == REG_TXDATA);
  assign st_wr_c    = wr_c & (wbs_adr_i[3:2] == REG_STATUS);

  // Hold drains from IDLE, or at the end of GAP for back-to-back frames.
  assign load_c     = hold_full & ((state == S_IDLE) | ((state == S_GAP) & phase_end_c));
  assign done_set_c = (state == S_LOW) & phase_end_c & (bits_left == '0);
  assign ovf_set_c  = tx_wr_c & hold_full & ~load_c;
  assign busy_c     = (state != S_IDLE) | hold_full;
  assign o_busy     = busy_c;

  // LEN of 0 or beyond the frame width means a full-width frame.
  assign len_eff_c  = ((len_q == '0) || (32'(len_q) > MAX_BITS)) ? CNT_W'(MAX_BITS)
                                                                  : CNT_W'(len_q);
  // Bit LEN-1 of the held word moves to the top so shifting is always from the MSB.
  assign aligned_c  = hold_data << (MAX_BITS - 32'(hold_len));

  always_comb begin
    rd_data_c = '0;
    case (wbs_adr_i[3:2])
      REG_LEN:    rd_data_c = 32'(len_q);
      REG_DIV:    rd_data_c = 32'(div_reg);
      REG_STATUS: begin
        rd_data_c[ST_BUSY] = busy_c;
        rd_data_c[ST_HOLD] = hold_full;
        rd_data_c[ST_OVF]  = ovf;
        rd_data_c[ST_DONE] = done;
      end
      default:    rd_data_c = '0;
    endcase
  end

  // Wishbone register file and hold buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      len_q     <= LEN_W'(LEN_RST);
      div_reg   <= DIV_W'(DIV_RST);
      hold_data <= '0;
      hold_len  <= '0;
      hold_full <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      wbs_ack_o <= wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
      if (acc_c && !wbs_we_i) begin
        wbs_dat_o <= rd_data_c;
      end
      if (wr_c && (wbs_adr_i[3:2] == REG_LEN)) begin
        len_q <= wbs_dat_i[LEN_W-1:0];
      end
      if (wr_c && (wbs_adr_i[3:2] == REG_DIV)) begin
        div_reg <= wbs_dat_i[DIV_W-1:0];
      end
      // A write landing on the same edge the FSM drains the hold is accepted.
      if (tx_wr_c && (!hold_full || load_c)) begin
        hold_data <= wbs_dat_i[MAX_BITS-1:0];
        hold_len  <= len_eff_c;
        hold_full <= 1'b1;
      end else if (load_c) begin
        hold_full <= 1'b0;
      end
      // Sticky flags: a set on the same edge beats a W1C clear.
      if (ovf_set_c) begin
        ovf <= 1'b1;
      end else if (st_wr_c && wbs_dat_i[ST_OVF]) begin
        ovf <= 1'b0;
      end
      if (done_set_c) begin
        done <= 1'b1;
      end else if (st_wr_c && wbs_dat_i[ST_DONE]) begin
        done <= 1'b0;
      end
    end
  end

  // Frame sequencer; every SPI pin is driven from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      o_ss_n <= 1'b1;
      o_sclk <= 1'b0;
      o_mosi <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      o_irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_c) begin
            state  <= S_SETUP;
            o_ss_n <= 1'b0;
            o_sclk <= 1'b0;
            o_mosi <= aligned_c[MAX_BITS-1];
          end
        end
        S_SETUP: begin
          if (phase_end_c) begin
            state  <= S_HIGH;
            o_sclk <= 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_end_c) begin
            state  <= S_LOW;
            o_sclk <= 1'b0;
            // The last bit stays on MOSI through the hold phase.
            if (bits_left != CNT_W'(1)) begin
              o_mosi <= next_bit;
            end
          end
        end
        S_LOW: begin
          if (phase_end_c) begin
            if (bits_left != '0) begin
              state  <= S_HIGH;
              o_sclk <= 1'b1;
            end else begin
              state  <= S_GAP;
              o_ss_n <= 1'b1;
              o_irq  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (phase_end_c) begin
            if (load_c) begin
              state  <= S_SETUP;
              o_ss_n <= 1'b0;
              o_mosi <= aligned_c[MAX_BITS-1];
            end else begin
              state  <= S_IDLE;
              o_mosi <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  rbz_spi_shifter #(
    .MAX_BITS (MAX_BITS),
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .run         (state != S_IDLE),
    .step        ((state == S_HIGH) & phase_end_c),
    .data        (aligned_c[MAX_BITS-2:0]),
    .nbits       (hold_len),
    .div         (div_reg),
    .phase_end_c (phase_end_c),
    .next_bit    (next_bit),
    .bits_left   (bits_left)
  );

endmodule

// File: tb/tb_rbz_reg_spi_ctrl.sv
// Self-checking bench for rbz_reg_spi_ctrl: a negedge SPI monitor records each
// frame, and expected frames are computed from the register values written.
module tb_rbz_reg_spi_ctrl;

  localparam logic [1:0] A_TX  = 2'd0;
  localparam logic [1:0] A_LEN = 2'd1;
  localparam logic [1:0] A_DIV = 2'd2;
  localparam logic [1:0] A_ST  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        sclk, mosi, ss_n, busy, irq;

  always #5 clk = ~clk;

  rbz_reg_spi_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .o_sclk    (sclk),
    .o_mosi    (mosi),
    .o_ss_n    (ss_n),
    .o_busy    (busy),
    .o_irq     (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // SPI frame monitor
  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          low;
    int          gap;
    logic        irq_end;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  logic   prev_ss = 1'b1;
  logic   prev_sclk = 1'b0;
  int     gap_cnt = 0;
  int     irq_total = 0;
  int     rises = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_ss   = 1'b1;
      prev_sclk = 1'b0;
      gap_cnt   = 0;
      rises     = 0;
    end else begin
      if (irq) irq_total++;
      if (!ss_n) begin
        if (prev_ss) begin
          cur.bits  = 0;
          cur.nbits = 0;
          cur.low   = 0;
          cur.gap   = gap_cnt;
          rises     = 0;
        end
        cur.low++;
        if (sclk && !prev_sclk) begin
          cur.bits = {cur.bits[30:0], mosi};
          cur.nbits++;
          rises++;
        end
      end else begin
        if (!prev_ss) begin
          cur.irq_end = irq;
          frames.push_back(cur);
          gap_cnt = 0;
        end
        gap_cnt++;
      end
      prev_ss   = ss_n;
      prev_sclk = sclk;
    end
  end

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'b0, a, 2'b00}; wdat = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    chk("wb_ack", 32'(ack), 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, 4'hF, r);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || !ss_n) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Program one frame and compare what appears on the pins with the register rules.
  task automatic run_frame(input int len_w, input int div, input logic [31:0] data);
    int          lf, n, q0;
    logic [63:0] mask;
    logic [31:0] r;
    frame_t      f;
    lf   = len_w % 64;
    n    = (lf == 0 || lf > 32) ? 32 : lf;
    mask = (64'd1 << n) - 64'd1;
    q0   = frames.size();
    wb_write(A_ST, 32'h8);
    wb_write(A_LEN, 32'(len_w));
    wb_write(A_DIV, 32'(div));
    wb_write(A_TX, data);
    wait_idle(3000);
    chk("frame_count", 32'(frames.size()), 32'(q0 + 1));
    if (frames.size() > q0) begin
      f = frames[$];
      chk("frame_bits", f.bits, 32'({32'h0, data} & mask));
      chk("frame_nbits", 32'(f.nbits), 32'(n));
      chk("frame_low", 32'(f.low), 32'((div + 1) * (1 + 2 * n)));
      chk("frame_irq", 32'(f.irq_end), 32'd1);
    end
    wb_read(A_ST, r);
    chk("status_done", r, 32'h8);
  endtask

  initial begin
    logic [31:0] r;
    int          q0, irq0, n;
    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and reset mid-idle
    @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    wb_write(A_LEN, 32'd5);
    wb_write(A_DIV, 32'd7);
    wb_read(A_LEN, r); chk("len_rb", r, 32'd5);
    #2 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wb_read(A_LEN, r); chk("rst_len", r, 32'd8);
    wb_read(A_DIV, r); chk("rst_div", r, 32'd1);
    wb_read(A_ST, r);  chk("rst_status", r, 32'd0);
    wb_read(A_TX, r);  chk("tx_reads_zero", r, 32'd0);

    // sel==0 write is acked but ignored
    wb_xfer(1'b1, A_LEN, 32'd3, 4'h0, r);
    wb_read(A_LEN, r); chk("sel0_ignored", r, 32'd8);

    // Basic frame, then full-width frame
    run_frame(8, 0, 32'hA5);
    run_frame(0, 2, 32'h8000_0001);

    // Back-to-back frames and overflow
    wb_write(A_ST, 32'h8);
    wb_write(A_LEN, 32'd8);
    wb_write(A_DIV, 32'd0);
    q0 = frames.size();
    wb_write(A_TX, 32'h3C);
    wb_write(A_TX, 32'hC3);
    wb_write(A_TX, 32'h55);
    wb_read(A_ST, r); chk("ovf_status", r, 32'h7);
    wb_write(A_ST, 32'h4);
    wb_read(A_ST, r); chk("ovf_cleared", r, 32'h3);
    wait_idle(1000);
    chk("b2b_count", 32'(frames.size()), 32'(q0 + 2));
    if (frames.size() >= q0 + 2) begin
      chk("b2b_bits0", frames[q0].bits, 32'h3C);
      chk("b2b_bits1", frames[q0+1].bits, 32'hC3);
      chk("b2b_low1", 32'(frames[q0+1].low), 32'd17);
      chk("b2b_gap", 32'(frames[q0+1].gap), 32'd1);
    end
    wb_read(A_ST, r); chk("b2b_status", r, 32'h8);

    // Randomised frames
    for (int i = 0; i < 10; i++) begin
      run_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), $urandom);
    end

    // Reset mid-frame after the third rising SCLK
    wb_write(A_LEN, 32'd16);
    wb_write(A_DIV, 32'd3);
    wb_write(A_TX, $urandom);
    n = 0;
    while (rises < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("third_rise", 32'(rises >= 3), 32'd1);
    irq0 = irq_total;
    q0   = frames.size();
    #2 reset = 1'b1;
    #1;
    chk("async_ss_n", 32'(ss_n), 32'd1);
    chk("async_sclk", 32'(sclk), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_irq", 32'(irq_total), 32'(irq0));
    chk("abort_no_frame", 32'(frames.size()), 32'(q0));
    wb_read(A_ST, r); chk("abort_status", r, 32'd0);
    run_frame(8, 0, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
